// File: rtl/sequence_checker_pkg.sv
// rtl/sequence_checker_pkg.sv - shared state type, data width and duty helper for sequence_checker
package sequence_checker_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_e;

    // A duty of zero or one larger than the period means "check every sample".
    function automatic logic [31:0] eff_duty(input logic [31:0] duty, input logic [31:0] per);
        return ((duty == 32'd0) || (duty > per)) ? per : duty;
    endfunction

endpackage

// File: rtl/sequence_checker_expect_gen.sv
// rtl/sequence_checker_expect_gen.sv - seq_expect_gen: per/iter counters and expected-value accumulator
module seq_expect_gen
    import sequence_checker_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int ITER_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                advance,
    input  logic [DATA_W-1:0]   start,
    input  logic [DATA_W-1:0]   incr,
    input  logic [DATA_W-1:0]   shift,
    input  logic [PERIOD_W-1:0] per,
    input  logic [ITER_W-1:0]   iter,
    output logic [DATA_W-1:0]   expected,
    output logic [DATA_W-1:0]   idx,
    output logic [PERIOD_W-1:0] per_cnt,
    output logic                last
);

    logic [DATA_W-1:0]   incr_q, incr_d, shift_q, shift_d, exp_q, exp_d, idx_q, idx_d;
    logic [PERIOD_W-1:0] per_q, per_d, per_cnt_q, per_cnt_d;
    logic [ITER_W-1:0]   iter_q, iter_d, it_cnt_q, it_cnt_d;
    logic                per_end;

    assign per_end  = (per_cnt_q == per_q - PERIOD_W'(1));
    assign last     = per_end && (it_cnt_q == iter_q - ITER_W'(1));
    assign expected = exp_q;
    assign idx      = idx_q;
    assign per_cnt  = per_cnt_q;

    always_comb begin
        incr_d    = incr_q;
        shift_d   = shift_q;
        per_d     = per_q;
        iter_d    = iter_q;
        exp_d     = exp_q;
        idx_d     = idx_q;
        per_cnt_d = per_cnt_q;
        it_cnt_d  = it_cnt_q;
        if (load) begin
            incr_d    = incr;
            shift_d   = shift;
            per_d     = per;
            iter_d    = iter;
            exp_d     = start;
            idx_d     = '0;
            per_cnt_d = '0;
            it_cnt_d  = '0;
        end else if (advance) begin
            idx_d = idx_q + DATA_W'(1);
            if (per_end) begin
                per_cnt_d = '0;
                exp_d     = exp_q + shift_q;
                it_cnt_d  = it_cnt_q + ITER_W'(1);
            end else begin
                per_cnt_d = per_cnt_q + PERIOD_W'(1);
                exp_d     = exp_q + incr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            incr_q    <= '0;
            shift_q   <= '0;
            per_q     <= '0;
            iter_q    <= '0;
            exp_q     <= '0;
            idx_q     <= '0;
            per_cnt_q <= '0;
            it_cnt_q  <= '0;
        end else begin
            incr_q    <= incr_d;
            shift_q   <= shift_d;
            per_q     <= per_d;
            iter_q    <= iter_d;
            exp_q     <= exp_d;
            idx_q     <= idx_d;
            per_cnt_q <= per_cnt_d;
            it_cnt_q  <= it_cnt_d;
        end
    end

endmodule

// File: rtl/sequence_checker.sv
// rtl/sequence_checker.sv - affine-sequence stream checker; SEQUENCE_CHECKER_MISMATCH_LOG_EN adds first_err_got/first_err_exp
module sequence_checker
    import sequence_checker_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int ITER_W   = 16,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                running,
    input  logic                in0_valid,
    input  logic [DATA_W-1:0]   in0,
    input  logic [DATA_W-1:0]   start,
    input  logic [DATA_W-1:0]   incr,
    input  logic [PERIOD_W-1:0] per,
    input  logic [PERIOD_W-1:0] duty,
    input  logic [DATA_W-1:0]   shift,
    input  logic [ITER_W-1:0]   iter,
`ifdef SEQUENCE_CHECKER_MISMATCH_LOG_EN
    output logic [DATA_W-1:0]   first_err_got,
    output logic [DATA_W-1:0]   first_err_exp,
`endif
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [DATA_W-1:0]   first_err_idx
);

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] eff_duty_q, eff_duty_d, per_cnt;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [DATA_W-1:0]   first_err_idx_q, first_err_idx_d, expected, idx;
    logic                consume, mismatch, last;

    // A run in the same cycle as a valid sample takes priority and drops the sample.
    assign consume  = (state_q == CHECK) && running && in0_valid && !run;
    assign mismatch = consume && (per_cnt < eff_duty_q) && (in0 != expected);

    seq_expect_gen #(
        .PERIOD_W (PERIOD_W),
        .ITER_W   (ITER_W)
    ) u_expect_gen (
        .clk      (clk),
        .rst_n    (rst),
        .load     (run),
        .advance  (consume),
        .start    (start),
        .incr     (incr),
        .shift    (shift),
        .per      (per),
        .iter     (iter),
        .expected (expected),
        .idx      (idx),
        .per_cnt  (per_cnt),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (run) begin
            state_d = ((per == '0) || (iter == '0)) ? DONE : CHECK;
        end else begin
            unique case (state_q)
                CHECK:   if (consume && last) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        done          = (state_q == DONE);
        pass          = done && (err_cnt_q == '0);
        err_cnt       = err_cnt_q;
        first_err_idx = first_err_idx_q;
    end

    always_comb begin
        eff_duty_d      = eff_duty_q;
        err_cnt_d       = err_cnt_q;
        first_err_idx_d = first_err_idx_q;
        if (run) begin
            eff_duty_d      = PERIOD_W'(eff_duty(32'(duty), 32'(per)));
            err_cnt_d       = '0;
            first_err_idx_d = '0;
        end else if (mismatch) begin
            if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
            if (err_cnt_q == '0) first_err_idx_d = idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eff_duty_q      <= '0;
            err_cnt_q       <= '0;
            first_err_idx_q <= '0;
        end else begin
            eff_duty_q      <= eff_duty_d;
            err_cnt_q       <= err_cnt_d;
            first_err_idx_q <= first_err_idx_d;
        end
    end

`ifdef SEQUENCE_CHECKER_MISMATCH_LOG_EN
    logic [DATA_W-1:0] got_q, got_d, exp_log_q, exp_log_d;

    always_comb begin
        got_d     = got_q;
        exp_log_d = exp_log_q;
        if (run) begin
            got_d     = '0;
            exp_log_d = '0;
        end else if (mismatch && (err_cnt_q == '0)) begin
            got_d     = in0;
            exp_log_d = expected;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            got_q     <= '0;
            exp_log_q <= '0;
        end else begin
            got_q     <= got_d;
            exp_log_q <= exp_log_d;
        end
    end

    assign first_err_got = got_q;
    assign first_err_exp = exp_log_q;
`endif

endmodule

// File: tb/tb_sequence_checker.sv
// tb/tb_sequence_checker.sv - scoreboard bench for sequence_checker; SEQUENCE_CHECKER_MISMATCH_LOG_EN checks log ports
module tb_sequence_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        running = 1'b1;
    logic        in0_valid = 1'b0;
    logic [31:0] in0 = '0;
    logic [31:0] start = '0;
    logic [31:0] incr = '0;
    logic [15:0] per = '0;
    logic [15:0] duty = '0;
    logic [31:0] shift = '0;
    logic [15:0] iter = '0;
    logic        done, pass;
    logic [15:0] err_cnt;
    logic [31:0] first_err_idx;
`ifdef SEQUENCE_CHECKER_MISMATCH_LOG_EN
    logic [31:0] first_err_got, first_err_exp;
`endif

    typedef struct {
        string       name;
        logic [15:0] err;
        logic [31:0] idx;
        logic        pass;
        logic [31:0] got;
        logic [31:0] xp;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        done_prev = 1'b0;
    logic [31:0] seq1 [8] = '{32'd100, 32'd104, 32'd108, 32'd112, 32'd120, 32'd124, 32'd128, 32'd132};

    sequence_checker dut (
        .clk           (clk),
        .rst           (rst_n),
        .run           (run),
        .running       (running),
        .in0_valid     (in0_valid),
        .in0           (in0),
        .start         (start),
        .incr          (incr),
        .per           (per),
        .duty          (duty),
        .shift         (shift),
        .iter          (iter),
`ifdef SEQUENCE_CHECKER_MISMATCH_LOG_EN
        .first_err_got (first_err_got),
        .first_err_exp (first_err_exp),
`endif
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            done_prev = 1'b0;
        end else begin
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected no result pending");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_err_cnt"}, 32'(err_cnt), 32'(e.err));
                    check({e.name, "_first_err_idx"}, first_err_idx, e.idx);
                    check({e.name, "_pass"}, 32'(pass), 32'(e.pass));
`ifdef SEQUENCE_CHECKER_MISMATCH_LOG_EN
                    check({e.name, "_got"}, first_err_got, e.got);
                    check({e.name, "_exp"}, first_err_exp, e.xp);
`endif
                end
            end
            done_prev = done;
        end
    end

    task automatic expect_result(input string name, input logic [15:0] err, input logic [31:0] idx,
                                 input logic ps, input logic [31:0] got, input logic [31:0] xp);
        exp_t e;
        e.name = name; e.err = err; e.idx = idx; e.pass = ps; e.got = got; e.xp = xp;
        sb.push_back(e);
    endtask

    // Config is scrambled right after the run edge to prove it is only sampled there.
    task automatic run_cfg(input logic [31:0] s, input logic [31:0] i, input logic [15:0] p,
                           input logic [31:0] sh, input logic [15:0] it, input logic [15:0] d);
        start = s; incr = i; per = p; shift = sh; iter = it; duty = d;
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        start = $urandom; incr = $urandom; shift = $urandom;
        per = 16'($urandom); iter = 16'($urandom); duty = 16'($urandom);
    endtask

    task automatic send(input logic [31:0] d);
        in0 = d; in0_valid = 1'b1; running = 1'b1;
        @(posedge clk); #1;
        in0_valid = 1'b0; in0 = $urandom;
    endtask

    task automatic send_gappy(input logic [31:0] d);
        int n;
        n = $urandom_range(0, 3);
        repeat (n) begin
            if ($urandom_range(0, 1) == 1) begin in0_valid = 1'b1; running = 1'b0; end
            else begin in0_valid = 1'b0; running = 1'b1; end
            in0 = $urandom;
            @(posedge clk); #1;
        end
        send(d);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d results pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_done", 32'(done), 32'd0);
        check("reset_pass", 32'(pass), 32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
        check("reset_first_err_idx", first_err_idx, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: clean sequence
        run_cfg(32'd100, 32'd4, 16'd4, 32'd8, 16'd2, 16'd0);
        expect_result("t1", 16'd0, 32'd0, 1'b1, 32'd0, 32'd0);
        for (int i = 0; i < 7; i++) send(seq1[i]);
        @(negedge clk);
        check("t1_done_early", 32'(done), 32'd0);
        #1;
        send(seq1[7]);
        drain("t1");

        // 2: fifth sample corrupted
        run_cfg(32'd100, 32'd4, 16'd4, 32'd8, 16'd2, 16'd0);
        expect_result("t2", 16'd1, 32'd4, 1'b0, 32'd0, 32'd120);
        for (int i = 0; i < 8; i++) send(i == 4 ? 32'd0 : seq1[i]);
        drain("t2");

        // 3: duty 2, samples at per_cnt 2,3 are not checked
        run_cfg(32'd100, 32'd4, 16'd4, 32'd8, 16'd2, 16'd2);
        expect_result("t3", 16'd0, 32'd0, 1'b1, 32'd0, 32'd0);
        for (int i = 0; i < 8; i++) send((i % 4) >= 2 ? 32'hDEAD0000 + 32'(i) : seq1[i]);
        drain("t3");

        // 4: stalls from running/in0_valid gaps
        run_cfg(32'd100, 32'd4, 16'd4, 32'd8, 16'd2, 16'd0);
        expect_result("t4", 16'd0, 32'd0, 1'b1, 32'd0, 32'd0);
        for (int i = 0; i < 8; i++) send_gappy(seq1[i]);
        drain("t4");

        // 5: 32-bit wrap
        run_cfg(32'hFFFFFFFE, 32'd1, 16'd4, 32'd1, 16'd1, 16'd0);
        expect_result("t5", 16'd0, 32'd0, 1'b1, 32'd0, 32'd0);
        send(32'hFFFFFFFE); send(32'hFFFFFFFF); send(32'd0); send(32'd1);
        drain("t5");

        // 6a: run mid-CHECK restarts; the sample offered with run is dropped
        run_cfg(32'd100, 32'd4, 16'd4, 32'd8, 16'd2, 16'd0);
        send(32'd100); send(32'd999);
        @(negedge clk);
        check("t6a_mid_err_cnt", 32'(err_cnt), 32'd1);
        check("t6a_mid_first_err_idx", first_err_idx, 32'd1);
        #1;
        in0 = 32'h12345678; in0_valid = 1'b1; running = 1'b1;
        run_cfg(32'd100, 32'd4, 16'd4, 32'd8, 16'd2, 16'd0);
        expect_result("t6a", 16'd0, 32'd0, 1'b1, 32'd0, 32'd0);
        for (int i = 0; i < 8; i++) send(seq1[i]);
        drain("t6a");

        // 6b: run with per==0 ends immediately with stats cleared
        run_cfg(32'd100, 32'd4, 16'd4, 32'd8, 16'd2, 16'd0);
        send(32'd100); send(32'd5);
        expect_result("t6b", 16'd0, 32'd0, 1'b1, 32'd0, 32'd0);
        run_cfg(32'd100, 32'd4, 16'd0, 32'd8, 16'd2, 16'd0);
        @(negedge clk);
        check("t6b_done_next_cycle", 32'(done), 32'd1);
        drain("t6b");

        // 6c: async reset mid-CHECK
        run_cfg(32'd100, 32'd4, 16'd4, 32'd8, 16'd2, 16'd0);
        send(32'd100); send(32'd7);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6c_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("t6c_rst_first_err_idx", first_err_idx, 32'd0);
        check("t6c_rst_done", 32'(done), 32'd0);
        check("t6c_rst_pass", 32'(pass), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running, expected finish");
        $fatal(1);
    end

endmodule
